counter_ram_scan: RTL and testbench
===================================

# counter_ram_scan

Address-sequencing read block: a 2-bit-mode universal register (load / shift right / shift left / count) drives the address of a small register-file RAM, whose word at that address is presented on `data_out`. It walks stored words in a table, e.g. a 4-byte-stride scan of word-aligned entries. It has a write port for filling the table.

## Interface
Parameters:
- `ADDR_W` = 4; width of address register and RAM address (depth = 2^ADDR_W).
- `DATA_W` = 8; RAM word width.
- `STEP` = 4; increment applied in count mode.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; low clears all state immediately.
- `en` in 1: address register update enable (0 = hold).
- `s` in 2: mode select for address register.
- `data_in` in ADDR_W: parallel-load value.
- `SISR` in 1: serial input for shift right (enters MSB).
- `SISL` in 1: serial input for shift left (enters LSB).
- `wr_en` in 1: RAM write enable.
- `wr_addr` in ADDR_W: RAM write address.
- `wr_data` in DATA_W: RAM write data.
- `addr_out` out ADDR_W: current address register value.
- `data_out` out DATA_W: RAM word at `addr_out`.

## Operation
- Address register `A` (ADDR_W bits). When `en`=1, on each rising clk edge:
  - `s`=00: `A <= data_in`.
  - `s`=01: `A <= {SISR, A[ADDR_W-1:1]}`.
  - `s`=10: `A <= {A[ADDR_W-2:0], SISL}`.
  - `s`=11: `A <= (A + STEP) mod 2^ADDR_W`. Wrap-around is silent; there is no carry out.
- When `en`=0, `A` holds regardless of `s`.
- RAM: 2^ADDR_W words of DATA_W bits. When `wr_en`=1, `mem[wr_addr] <= wr_data` on the rising edge. Writing is independent of `en` and `s`.
- Read is asynchronous (combinational): `data_out = mem[A]`. `addr_out = A`.
- Simultaneous write and address change on the same edge:
  - Both take effect.
  - After the edge, `data_out` shows `mem[new A]`, including the just-written word if `wr_addr` equals the new `A`.
- Reset (`reset`=0, asynchronous, any time including mid-scan):
  - `A` = 0.
  - All RAM words = 0.
  - Therefore `addr_out` = 0 and `data_out` = 0.
  - Writes and register updates are ignored while `reset` is low.
  - Normal operation resumes on the first rising edge after `reset` returns high.

## Timing
- Address-register latency: 1 cycle from mode/input sampling to new `addr_out`.
- Read latency: 0 cycles. `data_out` follows `addr_out` and RAM contents combinationally.
- Write-to-read: a word written at edge N is visible on `data_out` right after edge N if `A` addresses it.
- With `STEP`=4 and `ADDR_W`=4, continuous count mode visits 0 → 4 → 8 → 12 → 0 (period 4 cycles).
- No handshake. Every enabled cycle performs exactly one register operation.

## Test plan
- Reset: assert `reset`=0 mid-operation → `addr_out`=0 and `data_out`=0 immediately, without waiting for a clk edge. Read several addresses after release → all 0.
- Fill and scan:
  - Write mem[0]=3, mem[4]=7, mem[8]=1, mem[12]=9, then `s`=11, `en`=1.
  - `data_out` sequence: 3, 7, 1, 9, 3 on successive cycles.
  - `addr_out`: 0, 4, 8, 12, 0 (wrap).
- Load/shift (from A=0101):
  - `s`=00 with `data_in`=0101 → A=0101.
  - `s`=01 with SISR=1 → 1010.
  - `s`=10 with SISL=1 → 0101.
  - `s`=10 with SISL=0 → 1010.
- Hold: `en`=0 for 3 cycles in `s`=11 → `addr_out` unchanged. A write to the current address during the hold changes `data_out` right after the write edge.
- Simultaneous write and count: A=4, `s`=11, and write mem[8]=5 on the same edge → after the edge `addr_out`=8 and `data_out`=5.
- Async reset pulse between clk edges during count mode → A=0 immediately. Counting resumes 0 → 4 on the first edge after release.

Source files
------------

// File: rtl/counter_ram_scan.sv
// Address-sequencing read block: a 4-mode universal register (load / shift
// right / shift left / count by STEP) addresses a register-file RAM read combinationally.
module counter_ram_scan #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        s,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              SISR,
  input  logic              SISL,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    M_LOAD = 2'b00,
    M_SHR  = 2'b01,
    M_SHL  = 2'b10,
    M_CNT  = 2'b11
  } mode_e;

  logic [ADDR_W-1:0]             r_a;
  logic [ADDR_W-1:0]             w_a_nxt;
  logic [DEPTH-1:0][DATA_W-1:0]  r_mem;
  mode_e                         w_mode;

  assign w_mode = mode_e'(s);

  always_comb begin
    w_a_nxt = r_a;
    if (en) begin
      unique case (w_mode)
        M_LOAD: w_a_nxt = data_in;
        M_SHR:  w_a_nxt = {SISR, r_a[ADDR_W-1:1]};
        M_SHL:  w_a_nxt = {r_a[ADDR_W-2:0], SISL};
        M_CNT:  w_a_nxt = r_a + ADDR_W'(STEP);  // wraps silently
        default: w_a_nxt = r_a;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_a <= '0;
    else        r_a <= w_a_nxt;
  end

  // Whole table clears on reset, so storage is flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_mem <= '0;
    else if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign addr_out = r_a;
  assign data_out = r_mem[r_a];

endmodule

// File: tb/tb_counter_ram_scan.sv
// Directed bench for counter_ram_scan: fill/scan, load/shift, hold, write+count, async reset.
module tb_counter_ram_scan;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] s;
  logic [3:0] data_in;
  logic       SISR;
  logic       SISL;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] addr_out;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  counter_ram_scan #(.ADDR_W(4), .DATA_W(8), .STEP(4)) dut (
    .clk(clk), .reset(reset), .en(en), .s(s), .data_in(data_in),
    .SISR(SISR), .SISL(SISL), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .addr_out(addr_out), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; s = 2'b00; data_in = '0; SISR = 1'b0; SISL = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #2;
    n_cmp++; if (addr_out !== 4'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", addr_out); end
    n_cmp++; if (data_out !== 8'd0) begin n_err++; $display("FAIL reset_data got %0d want 0", data_out); end
    #8 reset = 1'b1;
  endtask

  task automatic test_fill_scan();
    logic [3:0] ea [4] = '{4'd4, 4'd8, 4'd12, 4'd0};
    logic [7:0] ed [4] = '{8'd7, 8'd1, 8'd9, 8'd3};
    logic [3:0] wa [4] = '{4'd0, 4'd4, 4'd8, 4'd12};
    logic [7:0] wd [4] = '{8'd3, 8'd7, 8'd1, 8'd9};
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = wa[i]; wr_data = wd[i];
      tick();
    end
    wr_en = 1'b0;
    n_cmp++; if (data_out !== 8'd3) begin n_err++; $display("FAIL scan_start_data got %0d want 3", data_out); end
    en = 1'b1; s = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (addr_out !== ea[i]) begin n_err++; $display("FAIL scan_addr[%0d] got %0d want %0d", i, addr_out, ea[i]); end
      n_cmp++; if (data_out !== ed[i]) begin n_err++; $display("FAIL scan_data[%0d] got %0d want %0d", i, data_out, ed[i]); end
    end
  endtask

  task automatic test_load_shift();
    logic [1:0] sm [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic       sr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       sl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] ea [4] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
    en = 1'b1; data_in = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      s = sm[i]; SISR = sr[i]; SISL = sl[i];
      tick();
      n_cmp++; if (addr_out !== ea[i]) begin n_err++; $display("FAIL ldsh[%0d] got %b want %b", i, addr_out, ea[i]); end
    end
    SISR = 1'b0; SISL = 1'b0;
  endtask

  task automatic test_hold();
    s = 2'b00; data_in = 4'd4;
    tick();
    n_cmp++; if (data_out !== 8'd7) begin n_err++; $display("FAIL hold_load_data got %0d want 7", data_out); end
    en = 1'b0; s = 2'b11;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h55; end
      tick();
      wr_en = 1'b0;
      n_cmp++; if (addr_out !== 4'd4) begin n_err++; $display("FAIL hold_addr[%0d] got %0d want 4", i, addr_out); end
      if (i == 1) begin
        n_cmp++; if (data_out !== 8'h55) begin n_err++; $display("FAIL hold_write_data got %0h want 55", data_out); end
      end
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; s = 2'b11;
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 8'd5;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (addr_out !== 4'd8) begin n_err++; $display("FAIL wrcnt_addr got %0d want 8", addr_out); end
    n_cmp++; if (data_out !== 8'd5) begin n_err++; $display("FAIL wrcnt_data got %0d want 5", data_out); end
  endtask

  task automatic test_async_reset();
    tick();
    n_cmp++; if (addr_out !== 4'd12) begin n_err++; $display("FAIL pre_pulse_addr got %0d want 12", addr_out); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (addr_out !== 4'd0) begin n_err++; $display("FAIL pulse_addr got %0d want 0", addr_out); end
    n_cmp++; if (data_out !== 8'd0) begin n_err++; $display("FAIL pulse_data got %0d want 0", data_out); end
    reset = 1'b1;
    tick();
    n_cmp++; if (addr_out !== 4'd4) begin n_err++; $display("FAIL resume_addr got %0d want 4", addr_out); end
    n_cmp++; if (data_out !== 8'd0) begin n_err++; $display("FAIL resume_data got %0h want 0", data_out); end
    // Held low across an edge: load and write must both be ignored.
    reset = 1'b0; s = 2'b00; data_in = 4'd8; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    tick();
    reset = 1'b1; en = 1'b0; wr_en = 1'b0;
    n_cmp++; if (addr_out !== 4'd0) begin n_err++; $display("FAIL rst_ignore_addr got %0d want 0", addr_out); end
    n_cmp++; if (data_out !== 8'd0) begin n_err++; $display("FAIL rst_ignore_data got %0h want 0", data_out); end
    en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      data_in = 4'(i * 4);
      tick();
      n_cmp++; if (data_out !== 8'd0) begin n_err++; $display("FAIL cleared_mem[%0d] got %0h want 0", i * 4, data_out); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_scan();
    test_load_shift();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
